// File: rtl/mac_neuron_sequencer_pkg.sv
// Shared types for the serial sign-magnitude neuron MAC.
// Operand layout, FSM states and accumulator sizing.
package fnn_pkg;

  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } sm8_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } state_t;

  function automatic logic sm8_sign(sm8_t v);
    return v.sign;
  endfunction

  function automatic logic [6:0] sm8_mag(sm8_t v);
    return v.mag;
  endfunction

  // Sum of n products of two mag_w-bit magnitudes can never overflow
  function automatic int acc_w_f(int mag_w, int n);
    return 2 * mag_w + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_neuron_sequencer_if.sv
// Controller/buffer bundle of the neuron MAC sequencer.
// slave = the sequencer, master = controller plus buffers.
interface mac_neuron_sequencer_if #(
  parameter int MAG_W  = 7,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 20
);

  logic              start;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [MAG_W:0]    a_data;
  logic [MAG_W:0]    w_data;
  logic [ACC_W:0]    out;
  logic              done;

  modport master (
    output start, a_data, w_data,
    input  busy, rd_en, rd_addr, out, done
  );

  modport slave (
    input  start, a_data, w_data,
    output busy, rd_en, rd_addr, out, done
  );

endinterface

// File: rtl/mac_neuron_sequencer_sm_mac_lane.sv
// Sign-magnitude MAC lane: pos/neg accumulators and final
// compare/subtract. Build option MAC_RELU_EN clamps negatives to 0.
module sm_mac_lane #(
  parameter int MAG_W = 7,
  parameter int ACC_W = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           cap,
  input  logic           fin,
  input  logic [MAG_W:0] a,
  input  logic [MAG_W:0] w,
  output logic [ACC_W:0] res
);

  localparam int PW = 2 * MAG_W;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic             neg_sel;
  logic [ACC_W-1:0] pos_sum;
  logic [ACC_W-1:0] neg_sum;
  logic [ACC_W:0]   res_nxt;

  assign prod     = PW'(a[MAG_W-1:0]) * PW'(w[MAG_W-1:0]);
  assign prod_ext = ACC_W'(prod);
  assign neg_sel  = a[MAG_W] ^ w[MAG_W];

  // Final signed result; equal sums give canonical +0
  always_comb begin
    res_nxt = '0;
    if (pos_sum > neg_sum) begin
      res_nxt = {1'b0, pos_sum - neg_sum};
    end
`ifdef MAC_RELU_EN
`else
    else if (neg_sum > pos_sum) begin
      res_nxt = {1'b1, neg_sum - pos_sum};
    end
`endif
  end

  // Accumulators steered by product sign; result latched on fin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_sum <= '0;
      neg_sum <= '0;
      res     <= '0;
    end else begin
      if (clear) begin
        pos_sum <= '0;
        neg_sum <= '0;
      end else if (cap) begin
        if (neg_sel) neg_sum <= neg_sum + prod_ext;
        else         pos_sum <= pos_sum + prod_ext;
      end
      if (fin) res <= res_nxt;
    end
  end

endmodule

// File: rtl/mac_neuron_sequencer.sv
// Neuron dot-product sequencer: FSM, index counter, handshake.
// Build option MAC_RELU_EN (in the lane) clamps negative results.
module mac_neuron_sequencer
  import fnn_pkg::*;
#(
  parameter int N_INPUTS = 62,
  parameter int MAG_W    = 7,
  parameter int ADDR_W   = 6,
  parameter int ACC_W    = acc_w_f(MAG_W, N_INPUTS)
) (
  input logic clk,
  input logic rst_n,
  mac_neuron_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              cap;
  logic              done_q;
  logic              clear;
  logic              fin;
  logic              rd_en;
  logic              busy;
  logic [ACC_W:0]    res;

  // State, index counter, capture delay and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      cap    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      cap    <= rd_en;
      done_q <= (state == FINISH);
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    clear     = 1'b0;
    fin       = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
          clear     = 1'b1;
        end
      end
      FETCH: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (addr == LAST) state_nxt = DRAIN;
        else              addr_nxt  = addr + 1'b1;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sm_mac_lane #(
    .MAG_W(MAG_W),
    .ACC_W(ACC_W)
  ) u_lane (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .cap  (cap),
    .fin  (fin),
    .a    (bus.a_data),
    .w    (bus.w_data),
    .res  (res)
  );

  assign bus.busy    = busy;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = addr;
  assign bus.out     = res;
  assign bus.done    = done_q;

endmodule
